// File: rtl/pq_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pq_access_arbiter
// Description : Round-robin arbiter sharing one min-tag priority queue among
//               NUM_REQ requesters. Serialises enqueue/dequeue ops, routes
//               each dequeue result back to its issuer, and never enqueues
//               into a full queue or dequeues from an empty one.
//               Optional feature macro: PQARB_TIMEOUT_EN (dequeue watchdog).
// Revision    : 1.0 - initial release
// ============================================================================
module pq_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ-1:0]            req_deq_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [NUM_REQ-1:0]            resp_valid_out,
  output logic [DATA_WIDTH-1:0]         resp_data_out,
  output logic [TAG_WIDTH-1:0]          resp_tag_out,
  output logic                          err_out,
  output logic                          pq_enq_out,
  output logic                          pq_deq_out,
  output logic [DATA_WIDTH-1:0]         pq_data_out,
  output logic [TAG_WIDTH-1:0]          pq_tag_out,
  input  logic                          pq_full_in,
  input  logic                          pq_empty_in,
  input  logic                          pq_valid_in,
  input  logic [DATA_WIDTH-1:0]         pq_data_in,
  input  logic [TAG_WIDTH-1:0]          pq_tag_in
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NUM_REQ_W = NUM_REQ[PTR_W:0];

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENQ    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DEQ    = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  state_t               state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   owner;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   elig_rot;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_off;
  logic [PTR_W:0]       grant_sum;
  logic [PTR_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [PTR_W-1:0]     next_ptr;
  logic                 grant_is_deq;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [TAG_WIDTH-1:0]  sel_tag;

`ifdef PQARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  wire unused_timeout = (TIMEOUT != 0);
`endif

  // A request may only compete when the queue can actually serve it now.
  assign eligible = req_valid_in &
                    ((req_deq_in & {NUM_REQ{~pq_empty_in}}) |
                     (~req_deq_in & {NUM_REQ{~pq_full_in}}));

  // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    elig_rot    = NUM_REQ'({eligible, eligible} >> rr_ptr);
    grant_found = 1'b0;
    grant_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        grant_found = 1'b1;
        grant_off   = k[PTR_W-1:0];
      end
    end
    grant_sum    = {1'b0, rr_ptr} + {1'b0, grant_off};
    grant_idx    = PTR_W'((grant_sum >= NUM_REQ_W) ? (grant_sum - NUM_REQ_W) : grant_sum);
    grant_onehot = NUM_REQ'(1) << grant_idx;
    next_ptr     = ({1'b0, grant_idx} == (NUM_REQ_W - 1'b1)) ? '0 : (grant_idx + 1'b1);
    grant_is_deq = req_deq_in[grant_idx];
    sel_data     = req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    sel_tag      = req_tag_in[grant_idx*TAG_WIDTH +: TAG_WIDTH];
  end

  // Accept strobe is the handshake itself: high only in the IDLE cycle that grants.
  assign req_ready_out = (state == ST_IDLE && grant_found && !rst_in) ? grant_onehot : '0;

`ifndef PQARB_TIMEOUT_EN
  assign err_out = 1'b0;
`endif

  // Operation sequencer: one op in flight, queue strobes and responses registered.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      pq_enq_out     <= 1'b0;
      pq_deq_out     <= 1'b0;
      pq_data_out    <= '0;
      pq_tag_out     <= '0;
      resp_valid_out <= '0;
      resp_data_out  <= '0;
      resp_tag_out   <= '0;
`ifdef PQARB_TIMEOUT_EN
      wait_cnt       <= '0;
      err_out        <= 1'b0;
`endif
    end else begin
      pq_enq_out     <= 1'b0;
      pq_deq_out     <= 1'b0;
      resp_valid_out <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            rr_ptr <= next_ptr;
            owner  <= grant_onehot;
            if (grant_is_deq) begin
              pq_deq_out <= 1'b1;
              state      <= ST_DEQ;
            end else begin
              pq_enq_out  <= 1'b1;
              pq_data_out <= sel_data;
              pq_tag_out  <= sel_tag;
              state       <= ST_ENQ;
            end
          end
        end
        ST_ENQ: begin
          state <= ST_SETTLE;
        end
        ST_DEQ: begin
`ifdef PQARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pq_valid_in) begin
            resp_valid_out <= owner;
            resp_data_out  <= pq_data_in;
            resp_tag_out   <= pq_tag_in;
            state          <= ST_SETTLE;
          end
`ifdef PQARB_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            // Queue never answered: release the owner with a zero result.
            err_out        <= 1'b1;
            resp_valid_out <= owner;
            resp_data_out  <= '0;
            resp_tag_out   <= '0;
            state          <= ST_SETTLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_SETTLE: begin
          // Lets the queue's full/empty flags catch up before the next grant.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pq_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pq_access_arbiter
// Description : Directed scoreboard bench for pq_access_arbiter with a
//               behavioural 8-entry min-tag priority queue attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pq_access_arbiter;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int TW    = 32;
  localparam int DEPTH = 8;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [N-1:0]      req_valid_in, req_deq_in, req_ready_out, resp_valid_out;
  logic [N*DW-1:0]   req_data_in;
  logic [N*TW-1:0]   req_tag_in;
  logic [DW-1:0]     resp_data_out, pq_data_out, pq_data_in;
  logic [TW-1:0]     resp_tag_out, pq_tag_out, pq_tag_in;
  logic              err_out, pq_enq_out, pq_deq_out;
  logic              pq_full_in, pq_empty_in, pq_valid_in;

  pq_access_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT(15)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_deq_in(req_deq_in),
    .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out),
    .resp_data_out(resp_data_out), .resp_tag_out(resp_tag_out),
    .err_out(err_out), .pq_enq_out(pq_enq_out), .pq_deq_out(pq_deq_out),
    .pq_data_out(pq_data_out), .pq_tag_out(pq_tag_out),
    .pq_full_in(pq_full_in), .pq_empty_in(pq_empty_in), .pq_valid_in(pq_valid_in),
    .pq_data_in(pq_data_in), .pq_tag_in(pq_tag_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int idx; logic [DW-1:0] data; logic [TW-1:0] tag; } resp_t;
  typedef struct { int idx; int gap; } grant_t;
  typedef struct { logic [DW-1:0] d; logic [TW-1:0] t; } ent_t;

  resp_t  exp_resp[$];
  grant_t exp_grant[$];
  int     lat_q[$];
  ent_t   pq[$];
  int     pq_cnt;
  int     mi;

  int compared   = 0;
  int mismatched = 0;
  int timeouts   = 0;
  int cyc        = 0;
  int last_grant = 0;
  bit done       = 1'b0;

  // Behavioural priority queue: min-tag dequeue, result one cycle after deq.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pq.delete();
      pq_cnt      <= 0;
      pq_valid_in <= 1'b0;
      pq_data_in  <= '0;
      pq_tag_in   <= '0;
    end else begin
      pq_valid_in <= 1'b0;
      if (pq_deq_out && pq.size() > 0) begin
        mi = 0;
        for (int k = 1; k < pq.size(); k++) if (pq[k].t < pq[mi].t) mi = k;
        pq_valid_in <= 1'b1;
        pq_data_in  <= pq[mi].d;
        pq_tag_in   <= pq[mi].t;
        pq.delete(mi);
      end
      if (pq_enq_out && pq.size() < DEPTH) pq.push_back('{pq_data_out, pq_tag_out});
      pq_cnt <= pq.size();
    end
  end
  assign pq_full_in  = (pq_cnt == DEPTH);
  assign pq_empty_in = (pq_cnt == 0);

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected grants/responses whenever the DUT presents them.
  always @(negedge clk_in) begin
    grant_t       g;
    resp_t        r;
    logic [N-1:0] oh;
    int           t0;
    if (done) begin
      chk("pending_grants", 64'(exp_grant.size()), 64'd0);
      chk("pending_resps", 64'(exp_resp.size()), 64'd0);
      chk("driver_timeouts", 64'(timeouts), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end else if (rst_in) begin
      lat_q.delete();
      chk("reset_outputs",
          64'({req_ready_out, resp_valid_out, pq_enq_out, pq_deq_out, err_out}), 64'd0);
      chk("reset_resp_data", 64'(resp_data_out), 64'd0);
      chk("reset_resp_tag", 64'(resp_tag_out), 64'd0);
    end else begin
      chk("enq_deq_overlap_or_err", 64'({pq_enq_out & pq_deq_out, err_out}), 64'd0);
      if (req_ready_out != '0) begin
        if (exp_grant.size() == 0) begin
          chk("unexpected_grant", 64'(req_ready_out), 64'd0);
        end else begin
          g  = exp_grant.pop_front();
          oh = '0;
          oh[g.idx] = 1'b1;
          chk("grant_onehot", 64'(req_ready_out), 64'(oh));
          if (g.gap > 0) chk("grant_spacing", 64'(cyc - last_grant), 64'(g.gap));
        end
        last_grant = cyc;
        if ((req_ready_out & req_deq_in) != '0) lat_q.push_back(cyc);
      end
      if (resp_valid_out != '0) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid_out), 64'd0);
        end else begin
          r  = exp_resp.pop_front();
          oh = '0;
          oh[r.idx] = 1'b1;
          chk("resp_route", 64'(resp_valid_out), 64'(oh));
          chk("resp_data", 64'(resp_data_out), 64'(r.data));
          chk("resp_tag", 64'(resp_tag_out), 64'(r.tag));
          if (lat_q.size() > 0) begin
            t0 = lat_q.pop_front();
            chk("deq_latency", 64'(cyc - t0), 64'd3);
          end else begin
            chk("latency_record_missing", 64'd1, 64'd0);
          end
        end
      end
    end
  end

  // One clock of stimulus; requesters drop valid after their accept edge.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk_in);
    acc = req_ready_out;
    @(posedge clk_in);
    #1;
    req_valid_in = req_valid_in & ~acc;
  endtask

  task automatic post(input int i, input bit deq, input logic [DW-1:0] d, input logic [TW-1:0] t);
    req_valid_in[i]            = 1'b1;
    req_deq_in[i]              = deq;
    req_data_in[i*DW +: DW]    = d;
    req_tag_in[i*TW +: TW]     = t;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (req_valid_in != '0 && n < 60) begin
      tick();
      n++;
    end
    if (req_valid_in != '0) begin
      timeouts++;
      $display("FAIL wait_accept: valid=0x%0h still pending, required all accepted", req_valid_in);
      req_valid_in = '0;
    end
  endtask

  task automatic settle();
    wait_accept();
    repeat (6) tick();
  endtask

  task automatic do_reset();
    rst_in       = 1'b1;
    req_valid_in = '0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; req_valid_in = '0; req_deq_in = '0; req_data_in = '0; req_tag_in = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    repeat (2) tick();

    // T1: enqueue from req0, dequeue from req1
    exp_grant.push_back('{0, 0});
    post(0, 1'b0, 32'hA, 32'd5);
    settle();
    exp_grant.push_back('{1, 0});
    exp_resp.push_back('{1, 32'hA, 32'd5});
    post(1, 1'b1, '0, '0);
    settle();
    do_reset();

    // T2: all four enqueue together from rr_ptr=0
    for (int i = 0; i < N; i++) exp_grant.push_back('{i, (i == 0) ? 0 : 3});
    for (int i = 0; i < N; i++) post(i, 1'b0, 32'h100 + i, 32'd40 + i);
    settle();
    // pointer back at 0: req0 wins over req3
    exp_grant.push_back('{0, 0});
    exp_grant.push_back('{3, 3});
    post(3, 1'b0, 32'h203, 32'd53);
    post(0, 1'b0, 32'h200, 32'd50);
    settle();
    // fill to DEPTH
    exp_grant.push_back('{2, 0});
    post(2, 1'b0, 32'h300, 32'd60);
    settle();
    exp_grant.push_back('{1, 0});
    post(1, 1'b0, 32'h301, 32'd61);
    settle();

    // T4: full queue, req1 enqueue must wait, req3 dequeue goes first
    post(1, 1'b0, 32'h400, 32'd70);
    repeat (6) tick();
    exp_grant.push_back('{3, 0});
    exp_grant.push_back('{1, 4});
    exp_resp.push_back('{3, 32'h100, 32'd40});
    post(3, 1'b1, '0, '0);
    settle();
    do_reset();

    // T3: empty queue, req2 dequeue waits behind req0 enqueue
    post(2, 1'b1, '0, '0);
    repeat (5) tick();
    exp_grant.push_back('{0, 0});
    exp_grant.push_back('{2, 3});
    exp_resp.push_back('{2, 32'h99, 32'd9});
    post(0, 1'b0, 32'h99, 32'd9);
    settle();

    // T5: enqueue tags 7,3,5 then three concurrent dequeues (rr_ptr=3)
    exp_grant.push_back('{0, 0});
    post(0, 1'b0, 32'h70, 32'd7);
    settle();
    exp_grant.push_back('{1, 0});
    post(1, 1'b0, 32'h30, 32'd3);
    settle();
    exp_grant.push_back('{2, 0});
    post(2, 1'b0, 32'h50, 32'd5);
    settle();
    exp_grant.push_back('{3, 0});
    exp_grant.push_back('{0, 4});
    exp_grant.push_back('{1, 4});
    exp_resp.push_back('{3, 32'h30, 32'd3});
    exp_resp.push_back('{0, 32'h50, 32'd5});
    exp_resp.push_back('{1, 32'h70, 32'd7});
    post(3, 1'b1, '0, '0);
    post(0, 1'b1, '0, '0);
    post(1, 1'b1, '0, '0);
    settle();

    // Reset while a dequeue is in flight: its response must never appear
    exp_grant.push_back('{0, 0});
    post(0, 1'b0, 32'h11, 32'd1);
    settle();
    exp_grant.push_back('{0, 0});
    post(0, 1'b1, '0, '0);
    wait_accept();
    do_reset();
    repeat (6) tick();
    // Recovery after reset
    exp_grant.push_back('{1, 0});
    post(1, 1'b0, 32'h22, 32'd2);
    settle();
    exp_grant.push_back('{1, 0});
    exp_resp.push_back('{1, 32'h22, 32'd2});
    post(1, 1'b1, '0, '0);
    settle();

    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
